// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - note-event valid/ready bundle between the CPU register block and the voice allocator
interface voice_allocator_if #(
   parameter int NOTEW = 7
);
   logic             ev_valid;
   logic             ev_ready;
   logic             ev_on;
   logic [NOTEW-1:0] ev_note;

   modport master (output ev_valid, output ev_on, output ev_note, input ev_ready);
   modport slave  (input ev_valid, input ev_on, input ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - note-on/off scheduler assigning notes to NVOICES envelope voices with oldest-voice stealing
module voice_allocator #(
   parameter int NVOICES = 4,
   parameter int NOTEW   = 7
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_sample_clock,
   voice_allocator_if.slave         ev,
   input  logic [NVOICES-1:0]       i_env_idle,
   output logic [NVOICES-1:0]       o_gate,
   output logic [NVOICES*NOTEW-1:0] o_voice_note,
   output logic                     o_stolen
);
   localparam int IDXW = $clog2(NVOICES);

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_KILL, S_ASSIGN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_on;
   logic [NOTEW-1:0]  r_note;
   logic [IDXW-1:0]   r_victim;
   logic [IDXW-1:0]   r_age   [NVOICES];
   logic [NOTEW-1:0]  r_vnote [NVOICES];
   logic [NVOICES-1:0] r_gate;
   logic              r_stolen;
   logic              r_sc_s1;
   logic              r_sc_s2;
   logic              r_sc_s3;
   logic              r_rise_seen;

   logic              w_sc_rise;
   logic              w_match_hit;
   logic [IDXW-1:0]   w_match_idx;
   logic              w_free_hit;
   logic [IDXW-1:0]   w_free_idx;
   logic              w_rel_hit;
   logic [IDXW-1:0]   w_rel_idx;
   logic [IDXW-1:0]   w_rel_age;
   logic [IDXW-1:0]   w_old_idx;
   logic [IDXW-1:0]   w_victim;
   logic              w_steal;
   logic              w_victim_gated;

   assign w_sc_rise   = r_sc_s2 & ~r_sc_s3;
   assign ev.ev_ready = (r_state == S_IDLE) && i_rst;
   assign o_gate      = r_gate;
   assign o_stolen    = r_stolen;

   for (genvar g = 0; g < NVOICES; g++) begin : g_pack
      assign o_voice_note[g*NOTEW +: NOTEW] = r_vnote[g];
   end

   // Candidate scans; descending loops leave the lowest matching index in place.
   always_comb begin
      w_match_hit = 1'b0;
      w_match_idx = '0;
      w_free_hit  = 1'b0;
      w_free_idx  = '0;
      w_rel_hit   = 1'b0;
      w_rel_idx   = '0;
      w_rel_age   = '0;
      w_old_idx   = '0;
      for (int i = NVOICES - 1; i >= 0; i--) begin
         if (r_gate[i] && (r_vnote[i] == r_note)) begin
            w_match_hit = 1'b1;
            w_match_idx = IDXW'(i);
         end
         if (!r_gate[i] && i_env_idle[i]) begin
            w_free_hit = 1'b1;
            w_free_idx = IDXW'(i);
         end
      end
      for (int i = 0; i < NVOICES; i++) begin
         if (!r_gate[i] && (!w_rel_hit || (r_age[i] > w_rel_age))) begin
            w_rel_hit = 1'b1;
            w_rel_idx = IDXW'(i);
            w_rel_age = r_age[i];
         end
         if (r_age[i] == IDXW'(NVOICES - 1)) begin
            w_old_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      w_steal = 1'b0;
      if (w_match_hit) begin
         w_victim = w_match_idx;
      end else if (w_free_hit) begin
         w_victim = w_free_idx;
      end else if (w_rel_hit) begin
         w_victim = w_rel_idx;
      end else begin
         w_victim = w_old_idx;
         w_steal  = (r_vnote[w_old_idx] != r_note);
      end
      w_victim_gated = r_gate[w_victim];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (ev.ev_valid) w_next = S_SEARCH;
         S_SEARCH: begin
            if (!r_on)               w_next = S_IDLE;
            else if (w_victim_gated) w_next = S_KILL;
            else                     w_next = S_ASSIGN;
         end
         S_KILL:   if (w_sc_rise && r_rise_seen) w_next = S_ASSIGN;
         S_ASSIGN: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_on        <= 1'b0;
         r_note      <= '0;
         r_victim    <= '0;
         r_gate      <= '0;
         r_stolen    <= 1'b0;
         r_sc_s1     <= 1'b0;
         r_sc_s2     <= 1'b0;
         r_sc_s3     <= 1'b0;
         r_rise_seen <= 1'b0;
         for (int i = 0; i < NVOICES; i++) begin
            r_age[i]   <= IDXW'(i);
            r_vnote[i] <= '0;
         end
      end else begin
         r_sc_s1  <= i_sample_clock;
         r_sc_s2  <= r_sc_s1;
         r_sc_s3  <= r_sc_s2;
         r_stolen <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (ev.ev_valid) begin
                  r_on   <= ev.ev_on;
                  r_note <= ev.ev_note;
               end
            end
            S_SEARCH: begin
               if (!r_on) begin
                  if (w_match_hit) r_gate[w_match_idx] <= 1'b0;
               end else begin
                  r_victim    <= w_victim;
                  r_stolen    <= w_steal;
                  r_rise_seen <= 1'b0;
                  if (w_victim_gated) r_gate[w_victim] <= 1'b0;
               end
            end
            S_KILL: begin
               if (w_sc_rise) r_rise_seen <= 1'b1;
            end
            S_ASSIGN: begin
               r_vnote[r_victim] <= r_note;
               r_gate[r_victim]  <= 1'b1;
               // Victim becomes youngest; only voices younger than it age, keeping a permutation.
               for (int i = 0; i < NVOICES; i++) begin
                  if (IDXW'(i) == r_victim) begin
                     r_age[i] <= '0;
                  end else if (r_age[i] < r_age[r_victim]) begin
                     r_age[i] <= r_age[i] + IDXW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed scoreboard bench for voice_allocator
module tb_voice_allocator;
   logic        clk;
   logic        rst;
   logic        sample_clock;
   logic [3:0]  env_idle;
   logic [3:0]  gate;
   logic [27:0] voice_note;
   logic        stolen;
   logic [7:0]  sc_cnt;

   int n_vec;
   int n_err;

   typedef struct {
      logic [3:0]  gate;
      logic [27:0] notes;
      logic        stolen;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_gate;
   logic [6:0] m_note [4];

   voice_allocator_if #(.NOTEW(7)) ev_if ();

   voice_allocator #(.NVOICES(4), .NOTEW(7)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_sample_clock (sample_clock),
      .ev             (ev_if.slave),
      .i_env_idle     (env_idle),
      .o_gate         (gate),
      .o_voice_note   (voice_note),
      .o_stolen       (stolen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial sc_cnt = 8'd0;
   always @(posedge clk) sc_cnt <= sc_cnt + 8'd1;
   assign sample_clock = sc_cnt[3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] pack_notes();
      return {m_note[3], m_note[2], m_note[1], m_note[0]};
   endfunction

   task automatic chk_ages(input string tag, input logic [7:0] exp);
      chk(tag, 32'({dut.r_age[3], dut.r_age[2], dut.r_age[1], dut.r_age[0]}), 32'(exp));
   endtask

   task automatic send(input logic on, input logic [6:0] note, input int voice,
                       input logic exp_st, input logic kill);
      exp_t e;
      int   n;
      logic obs_st;
      logic st_extra;
      n = 0;
      while (!ev_if.ev_ready && n < 20) begin
         step();
         n++;
      end
      chk("ready_before_ev", 32'(ev_if.ev_ready), 32'd1);
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = on;
      ev_if.ev_note  = note;
      if (voice >= 0) begin
         m_gate[voice] = on;
         if (on) m_note[voice] = note;
      end
      e.gate   = m_gate;
      e.notes  = pack_notes();
      e.stolen = exp_st;
      sb.push_back(e);
      step();
      ev_if.ev_valid = 1'b0;
      chk("search_not_ready", 32'(ev_if.ev_ready), 32'd0);
      st_extra = stolen;
      step();
      obs_st = stolen;
      if (on && !kill) begin
         chk("assign_not_ready", 32'(ev_if.ev_ready), 32'd0);
         step();
         st_extra = st_extra | stolen;
      end else if (on && kill) begin
         chk("kill_gates_low", 32'(gate), 32'(m_gate & ~(4'b1 << voice)));
         n = 0;
         while (!gate[voice] && n < 600) begin
            step();
            n++;
            if (!gate[voice]) st_extra = st_extra | stolen;
         end
         chk("kill_gate_returns", 32'(gate[voice]), 32'd1);
         chk("kill_len_ok", 32'((n >= 18) && (n <= 36)), 32'd1);
      end
      chk("ready_after_ev", 32'(ev_if.ev_ready), 32'd1);
      e = sb.pop_front();
      chk("gate", 32'(gate), 32'(e.gate));
      chk("voice_note", 32'(voice_note), 32'(e.notes));
      chk("stolen_k2", 32'(obs_st), 32'(e.stolen));
      chk("stolen_other", 32'(st_extra), 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b0;
      env_idle = 4'hF;
      ev_if.ev_valid = 1'b0;
      ev_if.ev_on = 1'b0;
      ev_if.ev_note = 7'd0;
      m_gate = 4'b0;
      for (int i = 0; i < 4; i++) m_note[i] = 7'd0;
      step(); step(); step();
      chk("rst_gate", 32'(gate), 32'd0);
      chk("rst_notes", 32'(voice_note), 32'd0);
      chk("rst_stolen", 32'(stolen), 32'd0);
      chk("rst_ready", 32'(ev_if.ev_ready), 32'd0);
      chk_ages("rst_ages", {2'd3, 2'd2, 2'd1, 2'd0});
      rst = 1'b1;
      step();
      chk("ready_after_rst", 32'(ev_if.ev_ready), 32'd1);

      send(1'b1, 7'd60, 0, 1'b0, 1'b0);
      send(1'b1, 7'd62, 1, 1'b0, 1'b0);
      send(1'b1, 7'd64, 2, 1'b0, 1'b0);
      send(1'b1, 7'd65, 3, 1'b0, 1'b0);
      chk_ages("ages_fill", {2'd0, 2'd1, 2'd2, 2'd3});

      send(1'b0, 7'd62, 1, 1'b0, 1'b0);
      chk_ages("ages_off", {2'd0, 2'd1, 2'd2, 2'd3});
      env_idle = 4'b1101;
      send(1'b1, 7'd67, 1, 1'b0, 1'b0);
      chk_ages("ages_release_reuse", {2'd1, 2'd2, 2'd0, 2'd3});
      env_idle = 4'hF;

      send(1'b1, 7'd70, 0, 1'b1, 1'b1);
      chk_ages("ages_steal", {2'd2, 2'd3, 2'd1, 2'd0});

      send(1'b1, 7'd64, 2, 1'b0, 1'b1);
      chk_ages("ages_retrig", {2'd3, 2'd0, 2'd2, 2'd1});

      send(1'b0, 7'd99, -1, 1'b0, 1'b0);
      chk_ages("ages_off_miss", {2'd3, 2'd0, 2'd2, 2'd1});

      // Steal of voice 3, aborted by reset while waiting in KILL
      ev_if.ev_valid = 1'b1;
      ev_if.ev_on    = 1'b1;
      ev_if.ev_note  = 7'd60;
      step();
      ev_if.ev_valid = 1'b0;
      step();
      chk("abort_stolen", 32'(stolen), 32'd1);
      chk("abort_gate_low", 32'(gate), 32'b0111);
      step(); step(); step();
      chk("abort_in_kill", 32'(ev_if.ev_ready), 32'd0);
      rst = 1'b0;
      step();
      chk("abort_gate", 32'(gate), 32'd0);
      chk("abort_notes", 32'(voice_note), 32'd0);
      chk("abort_ready", 32'(ev_if.ev_ready), 32'd0);
      chk_ages("abort_ages", {2'd3, 2'd2, 2'd1, 2'd0});
      rst = 1'b1;
      step();
      chk("abort_ready_release", 32'(ev_if.ev_ready), 32'd1);
      step(); step();
      chk("abort_no_late_gate", 32'(gate), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
